harmonic_sequencer: RTL and testbench

- Per-sample control engine for the additive oscillator, and successor to the fixed two-adder control loop.
- Sweeps harmonics 0..limit, handshaking with the sample position lookup and the harmonic scaler.
- Scales and accumulates each sine sample into one of NUM_CHANNELS internal accumulators, selected round-robin.
- Presents the latched channel totals to the DAC output stage once per sample period.
- Adds behaviour the earlier loop lacked: runtime harmonic limit, functional comb muting, saturating accumulation, a free-running sample clock, and overrun detection.

---
 rtl/harmonic_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_harmonic_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/harmonic_sequencer.sv
// -----------------------------------------------------------------------------
// harmonic_sequencer
//
// Per-sample control engine for the additive oscillator. Once per sample
// period it sweeps harmonics 0..limit, handshakes with the sample position
// lookup and the harmonic scaler, then scales each sine sample and adds it
// into one of NUM_CHANNELS saturating accumulators, chosen round-robin
// (harmonic h goes to channel h mod NUM_CHANNELS). On every sample tick the
// accumulators are latched onto o_Totals for the DAC stage and a new frame
// begins. A tick that arrives before a frame has finished aborts that frame.
// The partial totals are still delivered and the event is flagged as an
// overrun.
//
// Ports:
//   i_Clock, reset_n        main clock; asynchronous active-low reset
//   i_Harmonic_Limit        highest harmonic to process (sampled at frame start)
//   i_Comb_Enable           1 = harmonics in the comb notch are not accumulated
//   o_Harmonic              current harmonic index (to the lookup)
//   o_Next_Sample           pulse: start a lookup for o_Harmonic
//   i_Sample_Ready          level: i_Sample_Value is valid
//   i_Sample_Value          signed sine sample
//   i_Freq_Too_High         current harmonic is above Nyquist; ends the frame
//   o_Mult_Start            pulse: scaler steps to the next harmonic
//   o_Mult_Restart          pulse: scaler reloads its initial value
//   i_Mult                  unsigned scale factor, fraction of 2^MULT_BITS
//   i_Mult_Ready            level: i_Mult and i_Comb_Muted are valid
//   i_Comb_Muted            current harmonic falls in the comb notch
//   o_Totals                latched totals, channel c at [c*ACC_W +: ACC_W]
//   o_Totals_Valid          pulse once per sample tick (DAC start)
//   o_Overrun               pulse when a tick aborts an unfinished frame
//   o_Overrun_Count         saturating count of overruns since reset
// -----------------------------------------------------------------------------
module harmonic_sequencer #(
    parameter int NUM_CHANNELS    = 2,
    parameter int HARM_W          = 8,
    parameter int MAX_HARMONICS   = 64,
    parameter int SAMPLE_INTERVAL = 1000,
    parameter int SAMPLE_W        = 16,
    parameter int MULT_BITS       = 9,
    parameter int ACC_W           = 32
) (
    input  logic                          i_Clock,
    input  logic                          reset_n,
    input  logic [HARM_W-1:0]             i_Harmonic_Limit,
    input  logic                          i_Comb_Enable,
    output logic [HARM_W-1:0]             o_Harmonic,
    output logic                          o_Next_Sample,
    input  logic                          i_Sample_Ready,
    input  logic [SAMPLE_W-1:0]           i_Sample_Value,
    input  logic                          i_Freq_Too_High,
    output logic                          o_Mult_Start,
    output logic                          o_Mult_Restart,
    input  logic [MULT_BITS-1:0]          i_Mult,
    input  logic                          i_Mult_Ready,
    input  logic                          i_Comb_Muted,
    output logic [NUM_CHANNELS*ACC_W-1:0] o_Totals,
    output logic                          o_Totals_Valid,
    output logic                          o_Overrun,
    output logic [7:0]                    o_Overrun_Count
);

    localparam int TIMER_W = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
    localparam int PTR_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int PROD_W  = SAMPLE_W + MULT_BITS + 1;

    localparam logic [HARM_W-1:0]      MAX_IDX    = HARM_W'(MAX_HARMONICS - 1);
    localparam logic [TIMER_W-1:0]     TIMER_LAST = TIMER_W'(SAMPLE_INTERVAL - 1);
    localparam logic [PTR_W-1:0]       PTR_LAST   = PTR_W'(NUM_CHANNELS - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        MULT_WAIT,
        SAMPLE_WAIT,
        ACCUM,
        NEXT,
        DONE,
        WAIT_TICK
    } state_t;

    state_t state;
    state_t state_next;

    // Sample-rate timer. It is free-running and never touched by the FSM,
    // so ticks stay exactly SAMPLE_INTERVAL clocks apart even on overrun.
    logic [TIMER_W-1:0] timer;
    logic               tick;

    assign tick = (timer == TIMER_LAST);

    always_ff @(posedge i_Clock or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + TIMER_W'(1);
        end
    end

    // Frame context
    logic [HARM_W-1:0]          limit_q;
    logic [MULT_BITS-1:0]       mult_q;
    logic                       mute_q;
    logic [PTR_W-1:0]           ptr;
    logic signed [ACC_W-1:0]    acc [NUM_CHANNELS];

    // FSM control strobes
    logic frame_start;
    logic overrun;
    logic harm_last;
    logic advance;
    logic latch_mult;
    logic do_accum;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge i_Clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        overrun     = 1'b0;
        advance     = 1'b0;
        latch_mult  = 1'b0;
        do_accum    = 1'b0;
        harm_last   = (o_Harmonic >= limit_q) || i_Freq_Too_High;

        if (tick) begin
            // A tick always starts a new frame; outside IDLE/WAIT_TICK the
            // frame in flight is cut short (DONE included).
            frame_start = 1'b1;
            overrun     = (state != IDLE) && (state != WAIT_TICK);
            state_next  = MULT_WAIT;
        end else begin
            case (state)
                IDLE, WAIT_TICK: state_next = state;
                MULT_WAIT: begin
                    if (i_Mult_Ready) begin
                        latch_mult = 1'b1;
                        state_next = SAMPLE_WAIT;
                    end
                end
                SAMPLE_WAIT: begin
                    if (i_Sample_Ready) begin
                        state_next = ACCUM;
                    end
                end
                ACCUM: begin
                    // Muted harmonics still walk the full handshake so the
                    // lookup and scaler stay in step; only the add is skipped.
                    do_accum   = !mute_q;
                    state_next = NEXT;
                end
                NEXT: begin
                    if (harm_last) begin
                        state_next = DONE;
                    end else begin
                        advance    = 1'b1;
                        state_next = MULT_WAIT;
                    end
                end
                DONE:    state_next = WAIT_TICK;
                default: state_next = IDLE;
            endcase
        end
    end

    // Scale and saturating add for the selected channel.
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  scaled;
    logic signed [ACC_W-1:0]  acc_sel;
    logic [ACC_W:0]           sum;
    logic signed [ACC_W-1:0]  sum_sat;

    always_comb begin
        product = PROD_W'($signed(i_Sample_Value)) * PROD_W'($signed({1'b0, mult_q}));
        // Arithmetic shift floors toward -inf for negative products.
        scaled  = ACC_W'(product >>> MULT_BITS);
        acc_sel = acc[ptr];
        sum     = {acc_sel[ACC_W-1], acc_sel} + {scaled[ACC_W-1], scaled};
        // The extra sum bit disagreeing with the sign bit means the add
        // left the representable range; clamp instead of wrapping.
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            sum_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_sat = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge i_Clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the accumulator array is reset explicitly; a reset mid-frame
            // must not leak stale partial sums into the first totals after it.
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                acc[c] <= '0;
            end
            o_Totals        <= '0;
            o_Totals_Valid  <= 1'b0;
            o_Mult_Restart  <= 1'b0;
            o_Mult_Start    <= 1'b0;
            o_Next_Sample   <= 1'b0;
            o_Overrun       <= 1'b0;
            o_Overrun_Count <= '0;
            o_Harmonic      <= '0;
            ptr             <= '0;
            limit_q         <= '0;
            mult_q          <= '0;
            mute_q          <= 1'b0;
        end else begin
            o_Totals_Valid <= frame_start;
            o_Mult_Restart <= frame_start;
            o_Next_Sample  <= frame_start | advance;
            o_Mult_Start   <= advance;
            o_Overrun      <= overrun;

            if (overrun && (o_Overrun_Count != 8'hFF)) begin
                o_Overrun_Count <= o_Overrun_Count + 8'd1;
            end

            if (frame_start) begin
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    o_Totals[c*ACC_W +: ACC_W] <= acc[c];
                    acc[c]                     <= '0;
                end
                o_Harmonic <= '0;
                ptr        <= '0;
                limit_q    <= (i_Harmonic_Limit > MAX_IDX) ? MAX_IDX : i_Harmonic_Limit;
            end else begin
                if (latch_mult) begin
                    mult_q <= i_Mult;
                    mute_q <= i_Comb_Muted & i_Comb_Enable;
                end
                if (do_accum) begin
                    acc[ptr] <= sum_sat;
                end
                if (advance) begin
                    o_Harmonic <= o_Harmonic + HARM_W'(1);
                    ptr        <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_harmonic_sequencer.sv
// -----------------------------------------------------------------------------
// tb_harmonic_sequencer
//
// Scoreboard bench for harmonic_sequencer (3 channels, 12 harmonics max,
// 100-clock sample period, 17-bit accumulators). Each frame gets a per-harmonic
// table of sample, scale and mute values, plus limit, Nyquist cut-off and an
// optional stall point. A stub drives the lookup/scaler handshakes from that
// table with random ready delays. When a frame starts, its expected totals,
// computed directly from the frame rules, are queued. A monitor pops an entry
// on every o_Totals_Valid and compares totals, overrun flag/count, request
// pulse counts, the last harmonic reached and the tick spacing.
// -----------------------------------------------------------------------------
module tb_harmonic_sequencer;

    localparam int NC   = 3;
    localparam int HW   = 8;
    localparam int MAXH = 12;
    localparam int SI   = 100;
    localparam int SW   = 16;
    localparam int MB   = 9;
    localparam int AW   = 17;
    localparam int TW   = NC * AW;
    localparam longint ACC_HI = (64'sd1 <<< (AW - 1)) - 1;
    localparam longint ACC_LO = -(64'sd1 <<< (AW - 1));

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [HW-1:0] i_Harmonic_Limit = '0;
    logic          i_Comb_Enable = 1'b0;
    logic [HW-1:0] o_Harmonic;
    logic          o_Next_Sample;
    logic          i_Sample_Ready = 1'b0;
    logic [SW-1:0] i_Sample_Value = '0;
    logic          i_Freq_Too_High = 1'b0;
    logic          o_Mult_Start;
    logic          o_Mult_Restart;
    logic [MB-1:0] i_Mult = '0;
    logic          i_Mult_Ready = 1'b0;
    logic          i_Comb_Muted = 1'b0;
    logic [TW-1:0] o_Totals;
    logic          o_Totals_Valid;
    logic          o_Overrun;
    logic [7:0]    o_Overrun_Count;

    always #5 clk = ~clk;

    harmonic_sequencer #(
        .NUM_CHANNELS(NC), .HARM_W(HW), .MAX_HARMONICS(MAXH),
        .SAMPLE_INTERVAL(SI), .SAMPLE_W(SW), .MULT_BITS(MB), .ACC_W(AW)
    ) dut (
        .i_Clock(clk),
        .reset_n(rst_n),
        .i_Harmonic_Limit(i_Harmonic_Limit),
        .i_Comb_Enable(i_Comb_Enable),
        .o_Harmonic(o_Harmonic),
        .o_Next_Sample(o_Next_Sample),
        .i_Sample_Ready(i_Sample_Ready),
        .i_Sample_Value(i_Sample_Value),
        .i_Freq_Too_High(i_Freq_Too_High),
        .o_Mult_Start(o_Mult_Start),
        .o_Mult_Restart(o_Mult_Restart),
        .i_Mult(i_Mult),
        .i_Mult_Ready(i_Mult_Ready),
        .i_Comb_Muted(i_Comb_Muted),
        .o_Totals(o_Totals),
        .o_Totals_Valid(o_Totals_Valid),
        .o_Overrun(o_Overrun),
        .o_Overrun_Count(o_Overrun_Count)
    );

    typedef struct {
        logic [TW-1:0] totals;
        bit            ovr;
        int            cnt;
        int            req;
        int            last_h;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t zero_entry();
        exp_t e;
        e.totals = '0;
        e.ovr    = 1'b0;
        e.cnt    = 0;
        e.req    = 0;
        e.last_h = 0;
        return e;
    endfunction

    // Frame tables: "nxt" is prepared ahead, "cur" is the frame being played.
    int   nxt_samp [256];
    int   nxt_mult [256];
    bit   nxt_mute [256];
    int   nxt_limit, nxt_nyq, nxt_stall;
    bit   nxt_comb;
    int   cur_samp [256];
    int   cur_mult [256];
    bit   cur_mute [256];
    int   cur_nyq = 255;
    int   cur_stall = 255;
    bit   cur_comb = 1'b0;
    exp_t nxt_exp;
    int   gen_idx = 0;
    int   ovr_model = 0;

    // Build the next frame's stimulus and its expected result straight from
    // the frame rules: harmonics 0..min(limit, MAXH-1), cut after the Nyquist
    // harmonic, each unmuted one adds floor(sample*mult/512) to channel h%NC
    // with clamping. A stall freezes the frame at harmonic nxt_stall until the
    // tick, so only the harmonics before it count, and it is an overrun.
    task automatic gen_next();
        longint acc [NC];
        int     stop;
        int     last;
        bit     ovr;
        for (int h = 0; h < 16; h++) begin
            nxt_samp[h] = int'($urandom_range(0, 65535)) - 32768;
            nxt_mult[h] = int'($urandom_range(0, 511));
            nxt_mute[h] = 1'($urandom_range(0, 1));
        end
        nxt_limit = int'($urandom_range(0, 20));
        nxt_comb  = 1'($urandom_range(0, 1));
        nxt_nyq   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAXH - 1)) : 255;
        nxt_stall = 255;
        case (gen_idx)
            1: begin nxt_limit = 3;  nxt_comb = 0; nxt_nyq = 255; end
            2: begin nxt_limit = 4;  nxt_comb = 1; nxt_nyq = 255; end
            3: begin nxt_limit = 5;  nxt_comb = 0; nxt_nyq = 255; end
            4: begin nxt_limit = 40; nxt_nyq = 2; end
            5, 6: begin nxt_limit = 11; nxt_comb = 0; nxt_nyq = 255; end
            7: begin nxt_limit = 11; nxt_nyq = 255; nxt_stall = 0; end
            8: begin nxt_limit = 11; nxt_nyq = 255; nxt_stall = 5; end
            default: ;
        endcase
        for (int h = 0; h < 16; h++) begin
            case (gen_idx)
                1: begin nxt_samp[h] = 1000;   nxt_mult[h] = 256; end
                2: begin nxt_samp[h] = 512;    nxt_mult[h] = 511; nxt_mute[h] = (h == 1 || h == 3); end
                3: begin nxt_samp[h] = -300;   nxt_mult[h] = 256; end
                5: begin nxt_samp[h] = 32767;  nxt_mult[h] = 511; end
                6: begin nxt_samp[h] = -32768; nxt_mult[h] = 511; end
                default: ;
            endcase
        end
        if (gen_idx >= 40 && gen_idx < 310) begin
            nxt_limit = 11;
            nxt_nyq   = 255;
            nxt_stall = int'($urandom_range(0, 3));
        end

        stop = (nxt_limit > MAXH - 1) ? MAXH - 1 : nxt_limit;
        if (nxt_nyq < stop) stop = nxt_nyq;
        ovr  = (nxt_stall <= stop);
        last = ovr ? nxt_stall : stop;
        for (int c = 0; c < NC; c++) acc[c] = 0;
        for (int h = 0; h < (ovr ? last : last + 1); h++) begin
            if (!(nxt_mute[h] && nxt_comb)) begin
                longint v;
                v = (longint'(nxt_samp[h]) * longint'(nxt_mult[h])) >>> MB;
                acc[h % NC] = acc[h % NC] + v;
                if (acc[h % NC] > ACC_HI) acc[h % NC] = ACC_HI;
                if (acc[h % NC] < ACC_LO) acc[h % NC] = ACC_LO;
            end
        end
        for (int c = 0; c < NC; c++) nxt_exp.totals[c*AW +: AW] = AW'(acc[c]);
        nxt_exp.ovr    = ovr;
        nxt_exp.cnt    = 0;
        nxt_exp.req    = last + 1;
        nxt_exp.last_h = last;
        gen_idx++;
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Lookup/scaler stub: ready levels follow a random countdown restarted by
    // each request; data is taken from the current frame table by harmonic.
    initial begin : stub
        int mw;
        int sw;
        mw = 0;
        sw = 0;
        forever begin
            @(negedge clk);
            if (rst_n && o_Totals_Valid) begin
                exp_t e;
                cur_samp  = nxt_samp;
                cur_mult  = nxt_mult;
                cur_mute  = nxt_mute;
                cur_nyq   = nxt_nyq;
                cur_stall = nxt_stall;
                cur_comb  = nxt_comb;
                e = nxt_exp;
                if (e.ovr && ovr_model < 255) ovr_model++;
                e.cnt = ovr_model;
                sb_q.push_back(e);
                gen_next();
                i_Harmonic_Limit = HW'(nxt_limit);
            end
            if (o_Next_Sample) begin
                mw = int'($urandom_range(0, 3));
                sw = int'($urandom_range(0, 3));
            end else begin
                if (mw > 0) mw--;
                if (sw > 0) sw--;
            end
            i_Mult_Ready    = (mw == 0);
            i_Sample_Ready  = (sw == 0) && (int'(o_Harmonic) != cur_stall);
            i_Mult          = MB'(cur_mult[o_Harmonic]);
            i_Comb_Muted    = cur_mute[o_Harmonic];
            i_Sample_Value  = SW'(cur_samp[o_Harmonic]);
            i_Comb_Enable   = cur_comb;
            i_Freq_Too_High = (int'(o_Harmonic) == cur_nyq);
        end
    end

    int last_v = 0;
    int n_req  = 0;
    int n_mst  = 0;
    int last_h = 0;
    int frames = 0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && o_Totals_Valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: totals presented with no expected entry queued");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    for (int c = 0; c < NC; c++) begin
                        check($sformatf("frame%0d_ch%0d_total", frames, c),
                              longint'($signed(o_Totals[c*AW +: AW])),
                              longint'($signed(e.totals[c*AW +: AW])));
                    end
                    check($sformatf("frame%0d_overrun", frames), longint'(o_Overrun), longint'(e.ovr));
                    check($sformatf("frame%0d_overrun_count", frames), longint'(o_Overrun_Count), longint'(e.cnt));
                    check($sformatf("frame%0d_next_sample_pulses", frames), longint'(n_req), longint'(e.req));
                    check($sformatf("frame%0d_mult_start_pulses", frames), longint'(n_mst),
                          longint'((e.req > 0) ? e.req - 1 : 0));
                    check($sformatf("frame%0d_last_harmonic", frames), longint'(last_h), longint'(e.last_h));
                end
                check($sformatf("frame%0d_tick_spacing", frames), longint'(cyc - last_v), longint'(SI));
                check($sformatf("frame%0d_mult_restart", frames), longint'(o_Mult_Restart), 64'sd1);
                last_v = cyc;
                frames++;
                n_req  = int'(o_Next_Sample);
                n_mst  = int'(o_Mult_Start);
            end else begin
                n_req  = n_req + int'(o_Next_Sample);
                n_mst  = n_mst + int'(o_Mult_Start);
                last_h = int'(o_Harmonic);
            end
        end
    end

    task automatic wait_frames(input int n);
        int start;
        int budget;
        start  = frames;
        budget = (n + 2) * SI;
        while ((frames - start) < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if ((frames - start) < n) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: saw %0d frames, expected %0d", frames - start, n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_totals"},        longint'(o_Totals), 0);
        check({tag, "_totals_valid"},  longint'(o_Totals_Valid), 0);
        check({tag, "_harmonic"},      longint'(o_Harmonic), 0);
        check({tag, "_next_sample"},   longint'(o_Next_Sample), 0);
        check({tag, "_mult_start"},    longint'(o_Mult_Start), 0);
        check({tag, "_mult_restart"},  longint'(o_Mult_Restart), 0);
        check({tag, "_overrun"},       longint'(o_Overrun), 0);
        check({tag, "_overrun_count"}, longint'(o_Overrun_Count), 0);
    endtask

    initial begin : main
        gen_next();
        i_Harmonic_Limit = HW'(nxt_limit);
        sb_q.push_back(zero_entry());
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        last_v = cyc;

        // Random frames, directed cases, then a long run of stalled frames
        // that drives the overrun counter into saturation.
        wait_frames(320);

        // Asynchronous reset in the middle of a frame.
        wait_frames(1);
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        sb_q.delete();
        sb_q.push_back(zero_entry());
        ovr_model = 0;
        n_req     = 0;
        n_mst     = 0;
        last_h    = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        last_v = cyc;
        wait_frames(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
